// File: rtl/circle_if.sv
// Pixel-draw handshake and frame-buffer write port between a draw controller and circle.
interface circle_if;
  logic [2:0] colour;
  logic [7:0] centre_x;
  logic [6:0] centre_y;
  logic [7:0] radius;
  logic       start;
  logic       done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  modport master (
    output colour, centre_x, centre_y, radius, start,
    input  done, vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    input  colour, centre_x, centre_y, radius, start,
    output done, vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/circle.sv
// Bresenham circle outline rasteriser for the 160x120 frame buffer, one octant pixel per cycle.
module circle (
  input  logic     clk,
  input  logic     rst_n,
  circle_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, INIT, PLOT, UPDATE, DONE} state_t;

  state_t             state_reg;
  logic [2:0]         colour_reg;
  logic [7:0]         cx_reg;
  logic [6:0]         cy_reg;
  logic [7:0]         radius_reg;
  logic signed [9:0]  ox_reg, oy_reg;
  logic signed [10:0] crit_reg;
  logic [2:0]         oct_reg;

  logic signed [9:0]  ox_next, oy_next;
  logic signed [10:0] crit_next;
  logic signed [9:0]  p_ox, p_oy, a, b, cx_s, cy_s, pix_x, pix_y;
  logic [2:0]         p_oct;
  logic               pix_in, load;

  always_comb begin
    oy_next = oy_reg + 10'sd1;
    if (crit_reg <= 11'sd0) begin
      ox_next   = ox_reg;
      crit_next = crit_reg + $signed({oy_next, 1'b0}) + 11'sd1;
    end else begin
      ox_next   = ox_reg - 10'sd1;
      crit_next = crit_reg + $signed({oy_next - ox_next, 1'b0}) + 11'sd1;
    end

    // Pixel for the PLOT cycle that follows this one, so the outputs can be registered.
    p_ox  = ox_reg;
    p_oy  = oy_reg;
    p_oct = oct_reg + 3'd1;
    case (state_reg)
      INIT: begin
        p_ox  = $signed({2'b00, radius_reg});
        p_oy  = 10'sd0;
        p_oct = 3'd0;
      end
      UPDATE: begin
        p_ox  = ox_next;
        p_oy  = oy_next;
        p_oct = 3'd0;
      end
      default: ;
    endcase

    a     = p_oct[0] ? p_oy : p_ox;
    b     = p_oct[0] ? p_ox : p_oy;
    cx_s  = $signed({2'b00, cx_reg});
    cy_s  = $signed({3'b000, cy_reg});
    pix_x = (p_oct[2] ^ p_oct[1]) ? cx_s - a : cx_s + a;
    pix_y = p_oct[2] ? cy_s - b : cy_s + b;
    pix_in = (pix_x >= 10'sd0) && (pix_x <= 10'sd159) &&
             (pix_y >= 10'sd0) && (pix_y <= 10'sd119);

    load = (state_reg == INIT) ||
           (state_reg == PLOT && oct_reg != 3'd7) ||
           (state_reg == UPDATE && oy_next <= ox_next);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      colour_reg     <= '0;
      cx_reg         <= '0;
      cy_reg         <= '0;
      radius_reg     <= '0;
      ox_reg         <= '0;
      oy_reg         <= '0;
      crit_reg       <= '0;
      oct_reg        <= '0;
      bus.done       <= 1'b0;
      bus.vga_plot   <= 1'b0;
      bus.vga_x      <= '0;
      bus.vga_y      <= '0;
      bus.vga_colour <= '0;
    end else begin
      bus.vga_plot <= load && pix_in;
      if (load) begin
        bus.vga_x      <= pix_x[7:0];
        bus.vga_y      <= pix_y[6:0];
        bus.vga_colour <= colour_reg;
      end
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            colour_reg <= bus.colour;
            cx_reg     <= bus.centre_x;
            cy_reg     <= bus.centre_y;
            radius_reg <= bus.radius;
            state_reg  <= INIT;
          end
        end
        INIT: begin
          ox_reg    <= $signed({2'b00, radius_reg});
          oy_reg    <= 10'sd0;
          crit_reg  <= 11'sd1 - $signed({3'b000, radius_reg});
          oct_reg   <= 3'd0;
          state_reg <= PLOT;
        end
        PLOT: begin
          if (oct_reg == 3'd7) state_reg <= UPDATE;
          else                 oct_reg   <= oct_reg + 3'd1;
        end
        UPDATE: begin
          ox_reg   <= ox_next;
          oy_reg   <= oy_next;
          crit_reg <= crit_next;
          if (oy_next <= ox_next) begin
            oct_reg   <= 3'd0;
            state_reg <= PLOT;
          end else begin
            bus.done  <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          if (!bus.start) begin
            bus.done  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_circle.sv
// Self-checking bench for circle: directed and random draws against a Bresenham reference model.
module tb_circle;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  circle_if bus();
  circle dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  int checks = 0;
  int errors = 0;
  int ex[$];
  int ey[$];
  int n_iter;
  int np;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit onscreen(input int x, input int y);
    return (x >= 0) && (x <= 159) && (y >= 0) && (y <= 119);
  endfunction

  // Octant pixel list of the whole outline, in draw order.
  function automatic void model(input int cx, input int cy, input int r);
    int ox, oy, crit, px, py;
    ox = r; oy = 0; crit = 1 - r;
    ex.delete(); ey.delete(); n_iter = 0;
    do begin
      for (int o = 0; o < 8; o++) begin
        case (o)
          0: begin px = cx + ox; py = cy + oy; end
          1: begin px = cx + oy; py = cy + ox; end
          2: begin px = cx - ox; py = cy + oy; end
          3: begin px = cx - oy; py = cy + ox; end
          4: begin px = cx - ox; py = cy - oy; end
          5: begin px = cx - oy; py = cy - ox; end
          6: begin px = cx + ox; py = cy - oy; end
          default: begin px = cx + oy; py = cy - ox; end
        endcase
        ex.push_back(px);
        ey.push_back(py);
      end
      oy = oy + 1;
      if (crit <= 0) crit = crit + 2 * oy + 1;
      else begin
        ox = ox - 1;
        crit = crit + 2 * (oy - ox) + 1;
      end
      n_iter++;
    end while (oy <= ox);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a draw from IDLE and checks every cycle until done; leaves start high.
  task automatic run_draw(input string tag, input logic [2:0] col, input int cx,
                          input int cy, input int r, output int nplots);
    int cyc, budget, k, it, p, e, exp_cnt, tx, ty;
    bit exp_plot;
    model(cx, cy, r);
    exp_cnt = 0;
    for (int i = 0; i < ex.size(); i++) if (onscreen(ex[i], ey[i])) exp_cnt++;
    bus.colour = col;
    bus.centre_x = cx[7:0];
    bus.centre_y = cy[6:0];
    bus.radius = r[7:0];
    bus.start = 1'b1;
    budget = 2 + 9 * n_iter + 20;
    cyc = 0;
    nplots = 0;
    do begin
      tick();
      cyc++;
      bus.colour = 3'($urandom);
      bus.centre_x = 8'($urandom);
      bus.centre_y = 7'($urandom);
      bus.radius = 8'($urandom);
      if (bus.done === 1'b1) break;
      exp_plot = 1'b0;
      e = 0;
      if (cyc >= 2) begin
        k = cyc - 2; it = k / 9; p = k % 9;
        if (p < 8 && it < n_iter) begin
          e = it * 8 + p;
          exp_plot = onscreen(ex[e], ey[e]);
        end
      end
      chk({tag, " plot"}, bus.vga_plot, exp_plot);
      if (bus.vga_plot === 1'b1) nplots++;
      if (exp_plot) begin
        tx = ex[e]; ty = ey[e];
        chk({tag, " x"}, bus.vga_x, tx);
        chk({tag, " y"}, bus.vga_y, ty);
        chk({tag, " colour"}, bus.vga_colour, col);
      end
    end while (cyc < budget);
    chk({tag, " done_cycles"}, cyc - 1, 1 + 9 * n_iter);
    chk({tag, " plot_count"}, nplots, exp_cnt);
    $display("draw %s c=(%0d,%0d) r=%0d col=%0d iters=%0d plots=%0d cycles=%0d",
             tag, cx, cy, r, col, n_iter, nplots, cyc - 1);
  endtask

  task automatic release_start(input string tag);
    bus.start = 1'b0;
    tick();
    chk({tag, " done_drop"}, bus.done, 1'b0);
  endtask

  initial begin
    bus.colour = 3'b010;
    bus.centre_x = 8'd80;
    bus.centre_y = 7'd60;
    bus.radius = 8'd0;
    bus.start = 1'b1;
    rst_n = 1'b0;

    // start held high through reset: reset must win
    repeat (3) tick();
    chk("rst done", bus.done, 1'b0);
    chk("rst plot", bus.vga_plot, 1'b0);
    chk("rst x", bus.vga_x, 0);
    chk("rst y", bus.vga_y, 0);
    chk("rst colour", bus.vga_colour, 0);
    rst_n = 1'b1;

    run_draw("r0", 3'b010, 80, 60, 0, np);
    chk("r0 pulses", np, 8);
    release_start("r0");

    run_draw("r1", 3'b111, 80, 60, 1, np);
    chk("r1 pulses", np, 16);
    release_start("r1");

    run_draw("r40", 3'($urandom), 80, 60, 40, np);
    release_start("r40");

    run_draw("clip", 3'b101, 0, 0, 10, np);
    release_start("clip");

    // handshake: start held after done
    run_draw("hs", 3'b001, 30, 100, 25, np);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hs done_hold", bus.done, 1'b1);
      chk("hs no_redraw", bus.vga_plot, 1'b0);
    end
    release_start("hs");
    run_draw("hs2", 3'($urandom), $urandom_range(0, 159), $urandom_range(0, 119),
             $urandom_range(0, 80), np);
    release_start("hs2");

    // reset during the 3rd PLOT cycle of r=50
    bus.colour = 3'b110;
    bus.centre_x = 8'd80;
    bus.centre_y = 7'd60;
    bus.radius = 8'd50;
    bus.start = 1'b1;
    repeat (4) tick();
    chk("mid plot_before", bus.vga_plot, 1'b1);
    rst_n = 1'b0;
    tick();
    chk("mid plot", bus.vga_plot, 1'b0);
    chk("mid done", bus.done, 1'b0);
    chk("mid x", bus.vga_x, 0);
    chk("mid y", bus.vga_y, 0);
    chk("mid colour", bus.vga_colour, 0);
    bus.start = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("mid idle_plot", bus.vga_plot, 1'b0);
      chk("mid idle_done", bus.done, 1'b0);
    end
    $display("reset mid-draw r=50 checked");

    for (int i = 0; i < 4; i++) begin
      run_draw("rand", 3'($urandom), $urandom_range(0, 159), $urandom_range(0, 119),
               $urandom_range(0, 100), np);
      release_start("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
